// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, segment table and conversion state encoding
// for the multiplexed 4-digit seven-segment display controller.
package display_scan_ctrl_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low a..g patterns, entry d drives digit d
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    if (d <= 4'd9)
      return SEG_TABLE[d];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_bcd_iter.sv
// Iterative 16-bit double-dabble: one shift/adjust step per cycle.
// done is high during the final step; bcd is valid the cycle after.
import display_scan_ctrl_pkg::*;

module bcd_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic        active_q;
  logic [3:0]  cnt_q;
  logic [15:0] bin_q;
  logic [15:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = active_q & (cnt_q == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd      <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      bin_q    <= bin;
      bcd      <= '0;
    end else if (active_q) begin
      bcd      <= {adj[14:0], bin_q[15]};
      bin_q    <= {bin_q[14:0], 1'b0};
      cnt_q    <= cnt_q + 4'd1;
      if (done)
        active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Binary-to-BCD display scanner with per-slot blanking.
// Define DISPLAY_LZB_EN to blank leading zero digits.
import display_scan_ctrl_pkg::*;

module display_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  seven_segment,
  output logic [3:0]  seven_segment_select
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LIT  = CW'(PRESCALE - BLANK_CYCLES);

  conv_state_t   state_q;
  logic          start;
  logic          iter_done;
  logic          ovf_pend_q;
  logic [15:0]   bcd_res;
  logic [15:0]   digits_q;
  logic [CW-1:0] scan_cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    cur_digit;
  logic          lead_zero;
  logic [6:0]    seg_nxt;

  assign start = (state_q == IDLE) & load;

  bcd_iter u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (value),
    .done  (iter_done),
    .bcd   (bcd_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q    <= SHIFT;
            busy       <= 1'b1;
            ovf_pend_q <= value > 16'(MAX_DISPLAY);
          end
        end
        SHIFT: begin
          if (iter_done)
            state_q <= COMMIT;
        end
        COMMIT: begin
          state_q  <= IDLE;
          busy     <= 1'b0;
          digits_q <= bcd_res;
          overflow <= ovf_pend_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd0: cur_digit = digits_q[15:12];
      2'd1: cur_digit = digits_q[11:8];
      2'd2: cur_digit = digits_q[7:4];
      2'd3: cur_digit = digits_q[3:0];
    endcase
    lead_zero = 1'b0;
`ifdef DISPLAY_LZB_EN
    unique case (idx_q)
      2'd0:    lead_zero = digits_q[15:12] == 4'd0;
      2'd1:    lead_zero = digits_q[15:8] == 8'd0;
      2'd2:    lead_zero = digits_q[15:4] == 12'd0;
      default: lead_zero = 1'b0;
    endcase
`endif
    if (overflow)
      seg_nxt = SEG_DASH;
    else if (lead_zero)
      seg_nxt = SEG_BLANK;
    else
      seg_nxt = seg_of(cur_digit);
  end

  // Outputs are registered from the current count so select and segments move together
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q           <= '0;
      idx_q                <= '0;
      seven_segment_select <= 4'hF;
      seven_segment        <= SEG_BLANK;
    end else begin
      if (scan_cnt_q == CNT_LAST) begin
        scan_cnt_q <= '0;
        idx_q      <= idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + CW'(1);
      end
      if (scan_cnt_q < CNT_LIT) begin
        seven_segment_select <= ~(4'b0001 << idx_q);
        seven_segment        <= seg_nxt;
      end else begin
        seven_segment_select <= 4'hF;
        seven_segment        <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: scan timing, conversion,
// overflow, dropped loads, mid-conversion reset, mid-slot commit.
module tb_display_scan_ctrl;

  localparam int PS = 16;
  localparam int BL = 4;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] S7 = 7'h78;
  localparam logic [6:0] S9 = 7'h10;
  localparam logic [6:0] SD = 7'h3F;
  localparam logic [6:0] SB = 7'h7F;
`ifdef DISPLAY_LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct {
    logic [15:0] v;
    logic [6:0]  s [4];
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  sel;

  int total = 0;
  int bad = 0;
  vec_t vt [9];

  display_scan_ctrl #(
    .PRESCALE     (PS),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .value                (value),
    .load                 (load),
    .busy                 (busy),
    .overflow             (overflow),
    .seven_segment        (seg),
    .seven_segment_select (sel)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [15:0] v,
    input logic [6:0] a, b, c, d,
    input logic ov
  );
    vec_t r;
    r.v = v;
    r.s[0] = a;
    r.s[1] = b;
    r.s[2] = c;
    r.s[3] = d;
    r.ov = ov;
    return r;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, output int n);
    int w;
    w = 0;
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("idle wait", 32'(busy), 32'd0);
    @(negedge clk);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic frame(
    input string name,
    input logic [6:0] e [4],
    input logic eo
  );
    int lit [4];
    logic [6:0] seen [4];
    int badsel;
    int badblank;
    int ix;
    badsel = 0;
    badblank = 0;
    for (int i = 0; i < 4; i++) begin
      lit[i] = 0;
      seen[i] = 7'h00;
    end
    for (int k = 0; k < 4 * PS; k++) begin
      @(negedge clk);
      ix = -1;
      case (sel)
        4'b1110: ix = 0;
        4'b1101: ix = 1;
        4'b1011: ix = 2;
        4'b0111: ix = 3;
        4'b1111: if (seg !== SB) badblank++;
        default: badsel++;
      endcase
      if (ix >= 0) begin
        if (lit[ix] == 0 || seg !== e[ix])
          seen[ix] = seg;
        lit[ix]++;
      end
    end
    chk({name, " overflow"}, 32'(overflow), 32'(eo));
    chk({name, " bad selects"}, badsel, 0);
    chk({name, " blank segs"}, badblank, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s digit%0d seg", name, i), 32'(seen[i]), 32'(e[i]));
      chk($sformatf("%s digit%0d lit", name, i), lit[i], PS - BL);
    end
  endtask

  initial begin
    int n;
    int found;
    logic [3:0] ps;
    logic [3:0] es;
    logic [6:0] eg;

    vt[0] = mk(16'd1234, S1, S2, S3, S4, 1'b0);
    vt[1] = mk(16'd9999, S9, S9, S9, S9, 1'b0);
    vt[2] = mk(16'd10000, SD, SD, SD, SD, 1'b1);
    vt[3] = mk(16'd0, LZ, LZ, LZ, S0, 1'b0);
    vt[4] = mk(16'd42, LZ, LZ, S4, S2, 1'b0);
    vt[5] = mk(16'hFFFF, SD, SD, SD, SD, 1'b1);
    vt[6] = mk(16'd1000, S1, S0, S0, S0, 1'b0);
    vt[7] = mk(16'd7, LZ, LZ, LZ, S7, 1'b0);
    vt[8] = mk(16'd305, LZ, S3, S0, S5, 1'b0);

    // Reset state and exact scan timing from release
    repeat (3) @(negedge clk);
    chk("rst sel", 32'(sel), 32'hF);
    chk("rst seg", 32'(seg), 32'(SB));
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4 * PS; k++) begin
      @(negedge clk);
      if ((k % PS) < (PS - BL)) begin
        es = ~(4'b0001 << (k / PS));
        eg = ((k / PS) == 3) ? S0 : LZ;
      end else begin
        es = 4'hF;
        eg = SB;
      end
      chk($sformatf("scan sel k=%0d", k), 32'(sel), 32'(es));
      chk($sformatf("scan seg k=%0d", k), 32'(seg), 32'(eg));
    end

    // Table of conversions
    for (int i = 0; i < 9; i++) begin
      do_load(vt[i].v, n);
      chk($sformatf("busy len v=%0d", vt[i].v), n, 17);
      frame($sformatf("v=%0d", vt[i].v), vt[i].s, vt[i].ov);
    end

    // Loads during SHIFT and on the COMMIT cycle are dropped
    @(negedge clk);
    value = 16'd42;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    value = 16'd7;
    n = 0;
    for (int k = 1; k <= 17; k++) begin
      if (busy)
        n++;
      if (k == 5 || k == 17)
        load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
    chk("drop busy len", n, 17);
    chk("drop busy after commit", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("drop busy stays low", 32'(busy), 32'd0);
    frame("drop 42", vt[4].s, 1'b0);

    // Reset in the middle of a conversion
    @(negedge clk);
    value = 16'd5555;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort overflow", 32'(overflow), 32'd0);
    chk("abort sel", 32'(sel), 32'hF);
    chk("abort seg", 32'(seg), 32'(SB));
    frame("after abort", vt[3].s, 1'b0);
    do_load(16'd5555, n);
    chk("busy len 5555", n, 17);
    frame("v=5555", '{S5, S5, S5, S5}, 1'b0);

    // Commit lands inside the lit hundreds slot
    found = 0;
    ps = 4'hF;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      if (sel == 4'b1110 && ps != 4'b1110)
        found = 1;
      ps = sel;
    end
    chk("align to thousands", found, 1);
    repeat (4) @(negedge clk);
    value = 16'd1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (17) @(negedge clk);
    chk("midslot busy", 32'(busy), 32'd0);
    chk("midslot sel old", 32'(sel), 32'hD);
    chk("midslot seg old", 32'(seg), 32'(S5));
    @(negedge clk);
    chk("midslot sel new", 32'(sel), 32'hD);
    chk("midslot seg new", 32'(seg), 32'(S2));
    frame("midslot 1234", vt[0].s, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 50000, meaning clk cycles per digit slot (min 8).
REQ-002 Parameter BLANK_CYCLES, default 1000, meaning inter-digit blanking cycles at the end of each slot (must be < PRESCALE).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 value  in  16  unsigned binary number to display.
REQ-006 load  in  1  single-cycle request to convert and display value.
REQ-007 busy  out  1  conversion in progress; load ignored while high.
REQ-008 overflow  out  1  displayed value exceeded 9999.
REQ-009 seven_segment  out  7  segment pattern, bit0=a..bit6=g, active-low (0 = lit).
REQ-010 seven_segment_select  out  4  digit enable, active-low; bit0=thousands, bit1=hundreds, bit2=tens, bit3=ones.

Function
REQ-011 Conversion FSM: IDLE -> SHIFT (16 cycles, one double-dabble iteration per cycle) -> COMMIT (1 cycle) -> IDLE.
REQ-012 load sampled high in IDLE captures value on that edge; busy is high for exactly 17 cycles starting the next cycle.
REQ-013 On the COMMIT edge, all four digit registers and overflow update atomically; busy falls on the same edge.
REQ-014 load while busy is high, including the COMMIT cycle, is dropped with no queuing.
REQ-015 When value > 9999, all four digits show a dash (segment g only) and overflow=1; otherwise overflow=0.
REQ-016 Scan counter runs 0..PRESCALE-1 continuously, independent of conversion; digit index increments mod 4 when the counter wraps.
REQ-017 Scan order is thousands, hundreds, tens, ones, then repeat.
REQ-018 While counter < PRESCALE-BLANK_CYCLES, exactly one select bit is low (the current index); otherwise all select bits are high and seven_segment=7'h7F.
REQ-019 Digit registers committed mid-slot take effect on the next cycle, with no restart of the scan.
REQ-020 Decimal digits 0-9 use standard a-g patterns; the pattern for the active digit is registered, so select and segments change on the same edge.

Reset
REQ-021 While rst=1: conversion FSM returns to IDLE (in-flight conversion aborted), busy=0, overflow=0, digit registers=0, scan counter=0, digit index=0 (thousands).
REQ-022 Outputs during and on the cycle after reset: seven_segment_select=4'b1111, seven_segment=7'h7F.
REQ-023 The first enabled digit after reset release is thousands showing "0" (or blank per REQ-024).

Configuration
REQ-024 Macro DISPLAY_LZB_EN defined: leading-zero digits (thousands, hundreds, tens) are driven 7'h7F while their slot is active; ones is always shown; the dash display is unaffected.
REQ-025 Macro DISPLAY_LZB_EN undefined: all four digits are always shown, including leading zeros.

Structure
REQ-026 A shared package holds: NUM_DIGITS=4, MAX_DISPLAY=9999, segment constants SEG_BLANK=7'h7F and SEG_DASH, the 0-9 pattern table, and the FSM state enum {IDLE, SHIFT, COMMIT}.
REQ-027 One sub-module, bcd_iter, holds the iterative 16-bit double-dabble engine with start/done signalling and 16-bit BCD output; scan and segment logic stay in the top level.

Verification
REQ-028 Reset then no load, PRESCALE=16, BLANK_CYCLES=4 -> selects cycle 1110,1101,1011,0111 for 12 cycles each, all high for 4 cycles between; segments "0" (blank for leading digits if DISPLAY_LZB_EN).
REQ-029 load with value=1234 -> busy high exactly 17 cycles; digits read 1,2,3,4 in scan order afterwards; overflow=0.
REQ-030 load 0x270F (9999), then load 10000 -> first shows 9999; second shows four dashes with overflow=1.
REQ-031 load 42, then a second load 7 at cycle 5 and on the COMMIT cycle -> both ignored; display 0042 (or "  42" with DISPLAY_LZB_EN).
REQ-032 rst asserted at cycle 8 of a conversion of 5555 -> busy=0 next cycle; display 0; a fresh load of 5555 completes normally.
REQ-033 Commit during a lit slot -> segments change on the next edge; no select glitch; slot timing unchanged.
